// File: rtl/ram_pack_1xn_if.sv
// Narrow-in / wide-out stream bundle for ram_pack_1xn.
interface ram_pack_1xn_if #(
   parameter int WIDTHI = 18,
   parameter int ADDRW  = 9
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTHI-1:0]     in_data;
   logic                  in_last;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*WIDTHI-1:0]   out_data;
   logic                  out_last;
   logic [ADDRW:0]        count;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, count
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, count
   );
endinterface

// File: rtl/ram_pack_1xn.sv
// Width-up buffer: packs pairs of narrow words (low half first) into a
// simple-dual-port RAM and streams them out as 2x-wide words.
module ram_pack_1xn #(
   parameter int WIDTHI = 18,
   parameter int DEPTH  = 512,
   parameter int ADDRW  = 9
) (
   input  logic           clk,
   input  logic           rst,
   ram_pack_1xn_if.slave  bus
);
   localparam int WW = 2 * WIDTHI;

   logic [WIDTHI-1:0] r_hold_lo;
   logic              r_hold_vld;
   logic [ADDRW-1:0]  r_wr_ptr;
   logic [ADDRW-1:0]  r_rd_ptr;
   logic [ADDRW:0]    r_count;
   logic              r_rd_pend;
   logic [WW:0]       r_mem [DEPTH];
   logic [WW:0]       r_rdata;
   logic              r_out_valid;
   logic [WW-1:0]     r_out_data;
   logic              r_out_last;

   logic              w_full;
   logic              w_in_ready;
   logic              w_acc;
   logic              w_wr;
   logic              w_rd;
   logic [WW:0]       w_wdata;

   always_comb begin
      w_full     = (r_count == (ADDRW+1)'(DEPTH));
      w_in_ready = !rst && !w_full;
      w_acc      = bus.in_valid && w_in_ready;
      w_wr       = w_acc && (r_hold_vld || bus.in_last);
      // A lone last word is written with a zero upper half.
      w_wdata    = r_hold_vld ? {bus.in_last, bus.in_data, r_hold_lo}
                              : {1'b1, {WIDTHI{1'b0}}, bus.in_data};
      w_rd       = !rst && (r_count != '0) && !r_rd_pend
                   && (!r_out_valid || bus.out_ready);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_lo  <= '0;
         r_hold_vld <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_pend  <= 1'b0;
      end else begin
         if (w_acc) begin
            if (r_hold_vld) begin
               r_hold_vld <= 1'b0;
            end else if (!bus.in_last) begin
               r_hold_lo  <= bus.in_data;
               r_hold_vld <= 1'b1;
            end
         end
         if (w_wr) r_wr_ptr <= r_wr_ptr + ADDRW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + ADDRW'(1);
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (ADDRW+1)'(1);
            2'b01:   r_count <= r_count - (ADDRW+1)'(1);
            default: r_count <= r_count;
         endcase
         r_rd_pend <= w_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= w_wdata;
      if (w_rd) r_rdata <= r_mem[r_rd_ptr];
   end

   // A read is only issued when this register is free by the next edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (r_rd_pend) begin
         r_out_valid <= 1'b1;
         r_out_data  <= r_rdata[WW-1:0];
         r_out_last  <= r_rdata[WW];
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.count     = r_count;
endmodule

// File: tb/tb_ram_pack_1xn.sv
// Directed scoreboard bench for ram_pack_1xn with a small RAM depth.
module tb_ram_pack_1xn;
   localparam int W  = 18;
   localparam int D  = 16;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_pack_1xn_if #(.WIDTHI(W), .ADDRW(AW)) bus ();

   ram_pack_1xn #(.WIDTHI(W), .DEPTH(D), .ADDRW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;
   logic [2*W:0] sb[$];
   logic         m_hold = 1'b0;
   logic [W-1:0] m_lo   = '0;
   logic         rnd    = 1'b0;
   logic         cnt_mon = 1'b0;
   int           maxc   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [W-1:0] d, input logic l);
      if (m_hold) begin
         sb.push_back({l, d, m_lo});
         m_hold = 1'b0;
      end else if (l) begin
         sb.push_back({1'b1, {W{1'b0}}, d});
      end else begin
         m_lo   = d;
         m_hold = 1'b1;
      end
   endtask

   task automatic try_send(input logic [W-1:0] d, input logic l, output logic acc);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) model_push(d, l);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] d, input logic l);
      logic acc;
      acc = 1'b0;
      for (int n = 0; n < 200 && !acc; n++) try_send(d, l, acc);
      if (!acc) begin
         errors++;
         $error("FAIL send_timeout observed=no_accept expected=accept");
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) begin
         errors++;
         $error("FAIL drain_timeout observed=%0d expected=0", sb.size());
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
   end

   logic         stall_prev = 1'b0;
   logic [2*W+1:0] prev_out;
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) chk("hold_stable", {bus.out_valid, bus.out_last, bus.out_data}, prev_out);
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               errors++;
               $error("FAIL sb_extra observed=%0h expected=none", {bus.out_last, bus.out_data});
            end else begin
               chk("sb_data", {bus.out_last, bus.out_data}, sb.pop_front());
            end
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_out   = {1'b1, bus.out_last, bus.out_data};
         if (cnt_mon && int'(bus.count) > maxc) maxc = int'(bus.count);
      end
   end

   initial begin
      logic acc;
      int   nacc;
      int   n;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_count", bus.count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;

      // 1: first pair and its latency
      send(18'h00001, 1'b0);
      send(18'h00002, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("lat_early_valid", bus.out_valid, 0);
      @(negedge clk);
      chk("lat_valid", bus.out_valid, 1);
      chk("pair1_data", bus.out_data, 36'h000080001);
      chk("pair1_last", bus.out_last, 0);
      drain();

      // 2: lone last word, then a pair proves the half register is empty
      send(18'h3FFFF, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("lone_data", bus.out_data, 36'h00003FFFF);
      chk("lone_last", bus.out_last, 1);
      @(posedge clk);
      #1;
      send(18'h00007, 1'b0);
      send(18'h00008, 1'b1);
      drain();

      // 3: fill while stalled, then drain
      bus.out_ready = 1'b0;
      acc  = 1'b1;
      nacc = 0;
      for (int i = 0; i < 2 * D + 8 && acc; i++) begin
         try_send(18'h00200 + W'(i), 1'b0, acc);
         if (acc) nacc++;
      end
      @(negedge clk);
      chk("full_accepted", nacc, 2 * (D + 1));
      chk("full_count", bus.count, D);
      chk("full_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(18'h003AA, 1'b0);
      send(18'h003AB, 1'b1);
      drain();
      @(negedge clk);
      chk("drained_count", bus.count, 0);

      // 4: continuous streaming across pointer wraps
      @(posedge clk);
      #1;
      maxc    = 0;
      cnt_mon = 1'b1;
      for (int i = 0; i < 4 * D; i++) send(W'(i), 1'b0);
      drain();
      cnt_mon = 1'b0;
      chk("stream_maxcount_le2", (maxc <= 2), 1);

      // 5: random consumer stalls
      rnd = 1'b1;
      for (int i = 0; i < 40; i++) send(W'($urandom), (i == 39));
      rnd = 1'b0;
      @(posedge clk);
      #2;
      bus.out_ready = 1'b1;
      drain();

      // 6: reset with a held half and three words in RAM
      bus.out_ready = 1'b0;
      for (int i = 0; i < 9; i++) send(18'h00100 + W'(i), 1'b0);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("pre_rst_count", bus.count, 3);
      chk("pre_rst_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      chk("mid_rst_valid", bus.out_valid, 0);
      chk("mid_rst_count", bus.count, 0);
      sb.delete();
      m_hold = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(18'h00005, 1'b0);
      send(18'h00006, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("post_rst_pair", bus.out_data, 36'h000180005);
      drain();
      @(negedge clk);
      chk("end_count", bus.count, 0);
      chk("end_valid", bus.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
